// File: rtl/sum_seq_pkg.sv
// Shared types and constants for the serial operand summer.
// SUM_W is derived here so every file agrees on the result width.
package sum_seq_pkg;

    localparam int DEF_BITSIZE      = 4;
    localparam int DEF_NUM_OPERANDS = 10;
    localparam int CNT_W            = 4;
    localparam int SUM_GUARD        = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    // Four guard bits cover up to 16 full-scale operands.
    function automatic int sum_w(input int bitsize);
        return bitsize + SUM_GUARD;
    endfunction

endpackage

// File: rtl/sum_acc.sv
// Shared accumulator: one adder feeding one SUM_W register.
// The sum output is the combinational acc + addend.
module sum_acc
    import sum_seq_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int SUM_W   = sum_w(DEF_BITSIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [BITSIZE-1:0] addend,
    output logic [SUM_W-1:0]   sum
);

    logic [SUM_W-1:0] acc;

    assign sum = acc + SUM_W'(addend);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/sum_sequencer.sv
// Streams NUM_OPERANDS operands through one adder and hands out the sum.
// Define SUM_SEQ_ABORT_EN to add the abort input.
module sum_sequencer
    import sum_seq_pkg::*;
#(
    parameter int BITSIZE      = DEF_BITSIZE,
    parameter int NUM_OPERANDS = DEF_NUM_OPERANDS,
    localparam int SUM_W       = sum_w(BITSIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [BITSIZE-1:0] in_data,
    output logic               in_ready,
    output logic               busy,
    output logic               out_valid,
    output logic [SUM_W-1:0]   out_sum,
    input  logic               out_ready
`ifdef SUM_SEQ_ABORT_EN
    ,
    input  logic               abort
`endif
);

    state_t           state;
    state_t           state_nx;
    cnt_t             count;
    logic             xfer;
    logic             last;
    logic             kill;
    logic             acc_clr;
    logic             acc_en;
    logic [SUM_W-1:0] sum;

`ifdef SUM_SEQ_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    assign xfer    = in_valid && in_ready;
    assign last    = (count == cnt_t'(NUM_OPERANDS - 1));
    assign acc_clr = ((state == IDLE) && start) || kill;
    assign acc_en  = xfer && !kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer && last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (kill) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        unique case (1'b1)
            (state == IDLE):  busy     = 1'b0;
            (state == ACCUM): in_ready = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (acc_clr) begin
            count <= '0;
        end else if (acc_en) begin
            count <= count + cnt_t'(1);
        end
    end

    // The final operand bypasses the register so the result is ready
    // on the same edge that completes the job.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (kill) begin
            out_valid <= 1'b0;
        end else if (xfer && last) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
        end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    sum_acc #(
        .BITSIZE (BITSIZE),
        .SUM_W   (SUM_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .addend (in_data),
        .sum    (sum)
    );

endmodule
